rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
Four-requester round-robin arbiter with burst hold, sharing one resource (bus/memory port) among requesters 0..3.
- The granted requester keeps the grant until it signals completion, drops its request, or exhausts a hold budget.
- Priority then rotates to the requester after the one just served.
- Grants are registered, one-hot, and followed by one mandatory turnaround cycle.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held (legal range 1..15).
- CNT_W, 4, width of the internal hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines, bit i = requester i.
- done  input  4  end-of-burst strobe, bit i from requester i; only the bit of the current grantee is honoured.
- grant  output  4  registered one-hot grant; all-zero when idle.
- grant_vld  output  1  registered, equals OR of grant.
- grant_id  output  2  registered index of the current grantee; holds its last value when grant_vld=0.
- preempt  output  1  one-cycle registered pulse: the grant was removed by hold timeout.

Behaviour:
- Reset (rst=1 at a clk edge): grant=0000, grant_vld=0, grant_id=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides everything, including a burst in progress; grant drops at that same edge.
- ptr (2 bits) is the highest-priority requester. The search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- State IDLE:
  - If req==0000, stay in IDLE; outputs stay zero except grant_id, which holds.
  - Otherwise pick the first set bit in search order.
  - At the next edge: grant=onehot(w), grant_vld=1, grant_id=w, hold_cnt=1, state=BUSY.
  - Latency from req sampled high to grant high is 1 cycle.
- State BUSY (grantee g): release condition R = done[g] | ~req[g] | (hold_cnt==MAX_HOLD).
  - R=0: grant holds and hold_cnt increments.
  - R=1: at the next edge grant=0000, grant_vld=0, ptr=(g+1) mod 4, hold_cnt=0, state=IDLE.
  - preempt=1 for that single cycle only if done[g]=0 and req[g]=1 (pure timeout).
- hold_cnt counts cycles with grant high, including the first. A grant is therefore high for at most MAX_HOLD cycles.
- MAX_HOLD=1: every grant lasts exactly 1 cycle with preempt=1, unless done or a dropped req coincides.
- Turnaround: after any release, grant is 0000 for exactly one cycle before the next grant. A requester holding req continuously is re-served only after every other active requester has had a turn.
- Simultaneous done[g] and req[g] falling: one release, preempt=0.
- done[i] for i≠g is ignored, as are req changes of non-grantees while BUSY; they are re-evaluated in IDLE.
- grant is never multi-hot and never asserted for a requester whose req was low at the arbitration edge.
- ptr changes only on release, never in IDLE without a grant.

Test Plan:
1. Reset, then req=0001 held with done=0 and MAX_HOLD=8 → grant=0001 one cycle after req, high exactly 8 cycles; preempt=1 for 1 cycle as grant falls; 1 idle cycle; regrant 0001.
2. req=1111 held, each grantee pulses done in its 3rd grant cycle → grant sequence 0001, 0010, 0100, 1000, 0001, each 3 cycles long, 1-cycle gap between grants, preempt never set.
3. After requester 2 is served (ptr=3), req=0101 → next grant is 0001, not 0100 (wrap-around from ptr=3 to 0).
4. While grant=0010, pulse done=0001 and change req=1010 → 1000 → grant 0010 unaffected; it releases only when req[1] drops, and the next grant is 1000.
5. rst asserted in the 4th cycle of a burst with grant=0100 → at that edge grant=0000, grant_vld=0, preempt=0; with req=0100 still high after rst falls, grant=0001? No: ptr=0 so req=0100 → grant=0100 one cycle after rst deasserts.
6. req[1] drops in the same cycle done[1]=1 at hold_cnt=MAX_HOLD → single release, preempt=0, ptr=2.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// Four-requester round-robin arbiter with burst hold.
// A grantee keeps the resource until it strobes done, drops its request, or
// reaches MAX_HOLD grant cycles. Priority then rotates to the requester after
// the one just served. Every release is followed by one idle turnaround cycle.
//
//   state | meaning
//   IDLE  | no grant; arbitrate among active requests starting at ptr
//   BUSY  | grant held by grant_id; watch for done, dropped req or timeout
module rr_burst_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    output logic [3:0] grant,
    output logic       grant_vld,
    output logic [1:0] grant_id,
    output logic       preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [CNT_W-1:0]   hold_cnt, hold_nxt;
    logic [3:0]         grant_nxt;
    logic               vld_nxt;
    logic [1:0]         id_nxt;
    logic               pre_nxt;

    logic               found;
    logic [1:0]         win;
    logic               rel;
    logic               timeout;

    // First active request in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end

    assign timeout = (hold_cnt == CNT_W'(MAX_HOLD));
    assign rel     = done[grant_id] | ~req[grant_id] | timeout;

    // Next-state and registered-output decode
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        grant_nxt = grant;
        vld_nxt   = grant_vld;
        id_nxt    = grant_id;
        pre_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = 4'(1) << win;
                    vld_nxt   = 1'b1;
                    id_nxt    = win;
                    hold_nxt  = CNT_W'(1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (rel) begin
                    grant_nxt = 4'b0000;
                    vld_nxt   = 1'b0;
                    ptr_nxt   = grant_id + 2'd1;
                    hold_nxt  = '0;
                    // Flag only a pure timeout; done or a dropped req wins
                    pre_nxt   = ~done[grant_id] & req[grant_id];
                    state_nxt = IDLE;
                end else begin
                    hold_nxt  = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            grant     <= 4'b0000;
            grant_vld <= 1'b0;
            grant_id  <= 2'd0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            grant     <= grant_nxt;
            grant_vld <= vld_nxt;
            grant_id  <= id_nxt;
            preempt   <= pre_nxt;
        end
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (MAX_HOLD=8): hand sequences for the
// timeout and rotation cases, then a vector table for wrap-around, ignored
// strobes, reset mid-burst and coincident done/req-drop at the hold limit.
module tb_rr_burst_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic       grant_vld;
    logic [1:0] grant_id;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;

    rr_burst_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] done;
        logic [3:0] grant;
        logic [1:0] id;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs for the current cycle, then sample just after the edge
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn);
        rst  = r;
        req  = rq;
        done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                              input logic pre);
        check({tag, ".grant"},     grant,             g);
        check({tag, ".grant_vld"}, {3'b0, grant_vld}, {3'b0, |g});
        check({tag, ".grant_id"},  {2'b0, grant_id},  {2'b0, id});
        check({tag, ".preempt"},   {3'b0, preempt},   {3'b0, pre});
    endtask

    function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                                input logic [3:0] g, input logic [1:0] id, input logic pre);
        vec_t v;
        v.rst = r; v.req = rq; v.done = dn; v.grant = g; v.id = id; v.pre = pre;
        vecs.push_back(v);
    endfunction

    initial begin
        // Wrap-around: serve 2 so ptr=3, then 0101 must go to requester 0
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0);
        add(0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 0);
        // Non-grantee done and req changes ignored while 1 holds
        add(0, 4'b0101, 4'b0001, 4'b0000, 2'd0, 0);
        add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
        add(0, 4'b1010, 4'b0001, 4'b0010, 2'd1, 0);
        add(0, 4'b1010, 4'b0000, 4'b0010, 2'd1, 0);
        add(0, 4'b1000, 4'b0000, 4'b0000, 2'd1, 0);
        add(0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 0);
        // Reset in the 4th cycle of a burst on requester 2
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd3, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        add(1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 2'd2, 0);
        // Requester 1 reaches the hold limit while dropping req with done
        for (int i = 0; i < 8; i++) add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0);
        add(0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0);

        rst = 1'b1; req = '0; done = '0;
        step(1, 4'b0000, 4'b0000);
        step(1, 4'b0000, 4'b0000);
        expect_out("reset", 4'b0000, 2'd0, 0);

        // Single requester held: 8-cycle grant, timeout pulse, 1 idle, regrant
        for (int i = 0; i < 8; i++) begin
            step(0, 4'b0001, 4'b0000);
            expect_out($sformatf("hold%0d", i + 1), 4'b0001, 2'd0, 0);
        end
        step(0, 4'b0001, 4'b0000);
        expect_out("timeout", 4'b0000, 2'd0, 1);
        step(0, 4'b0001, 4'b0000);
        expect_out("regrant", 4'b0001, 2'd0, 0);

        // All requesting, each grantee strobes done in its 3rd grant cycle
        step(1, 4'b0000, 4'b0000);
        expect_out("rst2", 4'b0000, 2'd0, 0);
        for (int n = 0; n < 5; n++) begin
            logic [1:0] g;
            logic [3:0] oh;
            g  = 2'(n % 4);
            oh = 4'b0001 << g;
            for (int c = 0; c < 3; c++) begin
                step(0, 4'b1111, 4'b0000);
                expect_out($sformatf("rr%0d.c%0d", n, c + 1), oh, g, 0);
            end
            step(0, 4'b1111, oh);
            expect_out($sformatf("rr%0d.gap", n), 4'b0000, g, 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].done);
            expect_out($sformatf("v%0d", i), vecs[i].grant, vecs[i].id, vecs[i].pre);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
